mapper_mem_req: RTL and testbench

MAPPER_MEM_REQ -- requirements
Module: mapper_mem_req

---
 rtl/mapper_mem_pkg.sv | 20 ++
 rtl/mapper_mem_req_if.sv | 16 +
 rtl/mem_chan_slot.sv | 77 +++++++
 rtl/mapper_mem_req.sv | 142 ++++++++++++++
 tb/tb_mapper_mem_req.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mapper_mem_pkg.sv
// Shared types and constants for the mapper memory request block.
package mapper_mem_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } mem_state_e;

   typedef enum logic {
      CH_PRG = 1'b0,
      CH_CHR = 1'b1
   } mem_chan_e;

   // Value returned for reads that never reach memory.
   localparam logic [7:0] OPEN_BUS = 8'hFF;

   // After this many CHR grants taken over a waiting PRG, PRG gets the next turn.
   localparam int STREAK_MAX = 2;

endpackage

// File: rtl/mapper_mem_req_if.sv
// Memory-side request/acknowledge bus between the request block and memory.
interface mapper_mem_req_if #(
   parameter int ADDR_W = 22
);
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [7:0]        mem_wdata;
   logic              mem_ack;
   logic [7:0]        mem_rdata;

   modport master (output mem_req, mem_addr, mem_we, mem_wdata,
                   input  mem_ack, mem_rdata);
   modport slave  (input  mem_req, mem_addr, mem_we, mem_wdata,
                   output mem_ack, mem_rdata);
endinterface

// File: rtl/mem_chan_slot.sv
// One-deep pending slot for a single access channel (PRG or CHR).
// An incoming strobe is forwarded combinationally so an idle arbiter can
// issue it in the same cycle it arrives.
module mem_chan_slot #(
   parameter int ADDR_W = 22
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rd_i,
   input  logic              wr_i,
   input  logic              allow_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [7:0]        din_i,
   input  logic              issue_i,
   input  logic              ack_i,
   input  logic              tmo_i,
   output logic              avail_o,
   output logic [ADDR_W-1:0] addr_o,
   output logic              we_o,
   output logic [7:0]        wdata_o,
   output logic              ovr_o
);

   logic              pend_q, pend_d;
   logic              fly_q, fly_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              we_q, we_d;
   logic [7:0]        wdata_q, wdata_d;
   logic              strobe, accept;

   // Accept/replace/drop decision and next-state for the slot.
   always_comb begin
      strobe  = (rd_i | wr_i) & allow_i;
      // The ack cycle frees the slot, so a strobe there becomes the next entry.
      accept  = strobe & (~fly_q | ack_i);
      ovr_o   = strobe & fly_q & ~ack_i;
      avail_o = pend_q | accept;
      addr_o  = accept ? addr_i : addr_q;
      we_o    = accept ? wr_i   : we_q;
      wdata_o = accept ? din_i  : wdata_q;

      pend_d  = pend_q;
      fly_d   = fly_q;
      addr_d  = addr_q;
      we_d    = we_q;
      wdata_d = wdata_q;
      if (accept) begin
         pend_d  = 1'b1;
         addr_d  = addr_i;
         we_d    = wr_i;
         wdata_d = din_i;
      end
      if (ack_i | tmo_i) fly_d = 1'b0;
      if (issue_i) begin
         pend_d = 1'b0;
         fly_d  = 1'b1;
      end
   end

   // Slot registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         pend_q  <= 1'b0;
         fly_q   <= 1'b0;
         addr_q  <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
      end else begin
         pend_q  <= pend_d;
         fly_q   <= fly_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
      end
   end

endmodule

// File: rtl/mapper_mem_req.sv
// Arbitrates PRG and CHR mapper accesses onto a single memory request bus
// with timeout, open-bus reads and sticky error flags.
module mapper_mem_req
   import mapper_mem_pkg::*;
#(
   parameter int ADDR_W  = 22,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] prg_aout,
   input  logic              prg_allow,
   input  logic              prg_read,
   input  logic              prg_write,
   input  logic [7:0]        prg_din,
   output logic [7:0]        prg_dout,
   input  logic [ADDR_W-1:0] chr_aout,
   input  logic              chr_allow,
   input  logic              chr_read,
   input  logic              chr_write,
   input  logic [7:0]        chr_din,
   output logic [7:0]        chr_dout,
   output logic [1:0]        err_flags,
   mapper_mem_req_if.master  mem
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   mem_state_e        state_q;
   mem_chan_e         cur_q;
   logic [CNT_W-1:0]  cnt_q, cnt_nx;
   logic [1:0]        streak_q;
   logic              mem_req_q, we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [7:0]        wdata_q, pdout_q, cdout_q;
   logic [1:0]        err_q;

   logic              prg_avail, chr_avail, prg_we, chr_we, prg_ovr, chr_ovr;
   logic [ADDR_W-1:0] prg_addr, chr_addr;
   logic [7:0]        prg_wd, chr_wd;
   logic              pick_prg, issue, issue_prg, issue_chr;
   logic              ack, tmo, prg_ack, chr_ack, prg_tmo, chr_tmo, prg_open;

   mem_chan_slot #(.ADDR_W(ADDR_W)) u_prg (
      .clk(clk), .reset(reset),
      .rd_i(prg_read), .wr_i(prg_write), .allow_i(prg_allow),
      .addr_i(prg_aout), .din_i(prg_din),
      .issue_i(issue_prg), .ack_i(prg_ack), .tmo_i(prg_tmo),
      .avail_o(prg_avail), .addr_o(prg_addr), .we_o(prg_we),
      .wdata_o(prg_wd), .ovr_o(prg_ovr)
   );

   mem_chan_slot #(.ADDR_W(ADDR_W)) u_chr (
      .clk(clk), .reset(reset),
      .rd_i(chr_read), .wr_i(chr_write), .allow_i(chr_allow),
      .addr_i(chr_aout), .din_i(chr_din),
      .issue_i(issue_chr), .ack_i(chr_ack), .tmo_i(chr_tmo),
      .avail_o(chr_avail), .addr_o(chr_addr), .we_o(chr_we),
      .wdata_o(chr_wd), .ovr_o(chr_ovr)
   );

   // Arbitration and completion decode for the current cycle.
   always_comb begin
      pick_prg  = prg_avail & (~chr_avail | (streak_q == 2'(STREAK_MAX)));
      issue     = (state_q == ST_IDLE) & (prg_avail | chr_avail);
      issue_prg = issue & pick_prg;
      issue_chr = issue & ~pick_prg;
      ack       = (state_q == ST_BUSY) & mem.mem_ack;
      cnt_nx    = (cnt_q == CNT_W'(TIMEOUT)) ? cnt_q : cnt_q + 1'b1;
      tmo       = (state_q == ST_BUSY) & ~mem.mem_ack & (cnt_nx == CNT_W'(TIMEOUT));
      prg_ack   = ack & (cur_q == CH_PRG);
      chr_ack   = ack & (cur_q == CH_CHR);
      prg_tmo   = tmo & (cur_q == CH_PRG);
      chr_tmo   = tmo & (cur_q == CH_CHR);
      prg_open  = prg_read & ~prg_write & ~prg_allow;
   end

   // Request FSM with registered bus, read-data and error outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         cur_q     <= CH_PRG;
         cnt_q     <= '0;
         streak_q  <= '0;
         mem_req_q <= 1'b0;
         addr_q    <= '0;
         we_q      <= 1'b0;
         wdata_q   <= '0;
         pdout_q   <= OPEN_BUS;
         cdout_q   <= OPEN_BUS;
         err_q     <= '0;
      end else begin
         err_q[0] <= err_q[0] | prg_ovr | chr_ovr;
         case (state_q)
            ST_IDLE: begin
               if (issue) begin
                  state_q   <= ST_BUSY;
                  mem_req_q <= 1'b1;
                  cnt_q     <= '0;
                  cur_q     <= pick_prg ? CH_PRG : CH_CHR;
                  addr_q    <= pick_prg ? prg_addr : chr_addr;
                  we_q      <= pick_prg ? prg_we   : chr_we;
                  wdata_q   <= pick_prg ? prg_wd   : chr_wd;
                  streak_q  <= (~pick_prg & prg_avail) ? streak_q + 2'd1 : 2'd0;
               end
            end
            ST_BUSY: begin
               if (mem.mem_ack) begin
                  state_q   <= ST_IDLE;
                  mem_req_q <= 1'b0;
                  if (!we_q) begin
                     if (cur_q == CH_PRG) pdout_q <= mem.mem_rdata;
                     else                 cdout_q <= mem.mem_rdata;
                  end
               end else if (tmo) begin
                  state_q   <= ST_IDLE;
                  mem_req_q <= 1'b0;
                  err_q[1]  <= 1'b1;
                  if (!we_q) begin
                     if (cur_q == CH_PRG) pdout_q <= OPEN_BUS;
                     else                 cdout_q <= OPEN_BUS;
                  end
               end else begin
                  cnt_q <= cnt_nx;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
         // A refused PRG read is the newest access, so it overrides any ack data.
         if (prg_open) pdout_q <= OPEN_BUS;
      end
   end

   assign mem.mem_req   = mem_req_q;
   assign mem.mem_addr  = addr_q;
   assign mem.mem_we    = we_q;
   assign mem.mem_wdata = wdata_q;
   assign prg_dout      = pdout_q;
   assign chr_dout      = cdout_q;
   assign err_flags     = err_q;

endmodule

// File: tb/tb_mapper_mem_req.sv
// Bench for mapper_mem_req: directed scenarios plus randomized traffic,
// all checked each cycle against a transaction-level reference model.
module tb_mapper_mem_req;
   localparam int AW = 22;
   localparam int TO = 15;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset;
   logic [AW-1:0] prg_aout, chr_aout;
   logic          prg_allow, prg_read, prg_write;
   logic          chr_allow, chr_read, chr_write;
   logic [7:0]    prg_din, chr_din, prg_dout, chr_dout;
   logic [1:0]    err_flags;

   mapper_mem_req_if #(.ADDR_W(AW)) mem_bus ();

   mapper_mem_req #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .prg_aout(prg_aout), .prg_allow(prg_allow), .prg_read(prg_read),
      .prg_write(prg_write), .prg_din(prg_din), .prg_dout(prg_dout),
      .chr_aout(chr_aout), .chr_allow(chr_allow), .chr_read(chr_read),
      .chr_write(chr_write), .chr_din(chr_din), .chr_dout(chr_dout),
      .err_flags(err_flags), .mem(mem_bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model: index 0 = PRG, 1 = CHR.
   typedef struct {
      bit            v;
      logic [AW-1:0] a;
      bit            we;
      logic [7:0]    d;
   } acc_t;

   acc_t          pend [2];
   bit            m_busy;
   int            m_cur, m_age, m_streak;
   bit            m_req, m_we;
   logic [AW-1:0] m_addr;
   logic [7:0]    m_wdata;
   logic [7:0]    m_dout [2];
   logic [1:0]    m_err;

   task automatic model_step();
      bit            rd [2], wr [2], al [2];
      logic [AW-1:0] ad [2];
      logic [7:0]    dn [2];
      bit            ack, was_busy;
      int            pick;
      rd[0] = prg_read; wr[0] = prg_write; al[0] = prg_allow; ad[0] = prg_aout; dn[0] = prg_din;
      rd[1] = chr_read; wr[1] = chr_write; al[1] = chr_allow; ad[1] = chr_aout; dn[1] = chr_din;
      if (reset) begin
         for (int ch = 0; ch < 2; ch++) begin
            pend[ch].v = 0;
            m_dout[ch] = 8'hFF;
         end
         m_busy = 0; m_streak = 0; m_age = 0; m_cur = 0;
         m_req = 0; m_we = 0; m_addr = '0; m_wdata = '0; m_err = 2'b00;
         return;
      end
      was_busy = m_busy;
      ack = m_busy && (mem_bus.mem_ack === 1'b1);
      // Strobes: in-flight channel drops (unless acked now), else (re)fill the slot.
      for (int ch = 0; ch < 2; ch++) begin
         if ((rd[ch] || wr[ch]) && al[ch]) begin
            if (m_busy && m_cur == ch && !ack) m_err[0] = 1'b1;
            else pend[ch] = '{1'b1, ad[ch], wr[ch], dn[ch]};
         end
      end
      if (was_busy) begin
         if (ack) begin
            m_busy = 0; m_req = 0;
            if (!m_we) m_dout[m_cur] = mem_bus.mem_rdata;
         end else if (m_age + 1 == TO) begin
            m_busy = 0; m_req = 0; m_err[1] = 1'b1;
            if (!m_we) m_dout[m_cur] = 8'hFF;
         end else begin
            m_age++;
         end
      end else if (pend[0].v || pend[1].v) begin
         pick = (pend[1].v && !(pend[0].v && m_streak == 2)) ? 1 : 0;
         if (pick == 1 && pend[0].v) m_streak++;
         else m_streak = 0;
         m_busy = 1; m_cur = pick; m_age = 0; m_req = 1;
         m_addr = pend[pick].a; m_we = pend[pick].we; m_wdata = pend[pick].d;
         pend[pick].v = 0;
      end
      if (prg_read && !prg_write && !prg_allow) m_dout[0] = 8'hFF;
   endtask

   task automatic check_all(string ph);
      chk({ph, "_req"}, 32'(mem_bus.mem_req), 32'(m_req));
      if (m_req) begin
         chk({ph, "_addr"}, 32'(mem_bus.mem_addr), 32'(m_addr));
         chk({ph, "_we"}, 32'(mem_bus.mem_we), 32'(m_we));
         if (m_we) chk({ph, "_wdata"}, 32'(mem_bus.mem_wdata), 32'(m_wdata));
      end
      chk({ph, "_prg_dout"}, 32'(prg_dout), 32'(m_dout[0]));
      chk({ph, "_chr_dout"}, 32'(chr_dout), 32'(m_dout[1]));
      chk({ph, "_err"}, 32'(err_flags), 32'(m_err));
   endtask

   // Inputs for this cycle are already driven; advance model and DUT one clock.
   task automatic tick(string ph);
      model_step();
      @(posedge clk);
      @(negedge clk);
      check_all(ph);
   endtask

   task automatic quiet();
      reset = 0;
      prg_read = 0; prg_write = 0; prg_allow = 1;
      chr_read = 0; chr_write = 0; chr_allow = 1;
      mem_bus.mem_ack = 0;
   endtask

   int hi, rises;
   bit prev;

   initial begin
      quiet();
      reset = 1;
      prg_aout = '0; chr_aout = '0; prg_din = '0; chr_din = '0;
      mem_bus.mem_rdata = '0;
      @(negedge clk);
      tick("rst");
      chk("rst_req", 32'(mem_bus.mem_req), 0);
      chk("rst_addr", 32'(mem_bus.mem_addr), 0);
      chk("rst_we", 32'(mem_bus.mem_we), 0);
      chk("rst_wdata", 32'(mem_bus.mem_wdata), 0);
      chk("rst_prg_dout", 32'(prg_dout), 32'h0FF);
      chk("rst_chr_dout", 32'(chr_dout), 32'h0FF);
      chk("rst_err", 32'(err_flags), 0);

      // CHR read, ack in the third request cycle.
      quiet(); chr_read = 1; chr_aout = 22'h200FD8;
      tick("t1");
      chk("t1_req_lat", 32'(mem_bus.mem_req), 1);
      chk("t1_addr", 32'(mem_bus.mem_addr), 32'h200FD8);
      quiet(); tick("t1");
      quiet(); tick("t1");
      quiet(); mem_bus.mem_ack = 1; mem_bus.mem_rdata = 8'h5A;
      tick("t1");
      chk("t1_chr_dout", 32'(chr_dout), 32'h5A);
      chk("t1_req_drop", 32'(mem_bus.mem_req), 0);

      // Simultaneous PRG and CHR reads: CHR first, PRG right after.
      quiet(); prg_read = 1; prg_aout = 22'h012345; chr_read = 1; chr_aout = 22'h300001;
      tick("t2");
      chk("t2_first", 32'(mem_bus.mem_addr), 32'h300001);
      quiet(); mem_bus.mem_ack = 1; mem_bus.mem_rdata = 8'h22;
      tick("t2");
      chk("t2_gap", 32'(mem_bus.mem_req), 0);
      quiet(); tick("t2");
      chk("t2_second_req", 32'(mem_bus.mem_req), 1);
      chk("t2_second", 32'(mem_bus.mem_addr), 32'h012345);
      quiet(); mem_bus.mem_ack = 1; mem_bus.mem_rdata = 8'h11;
      tick("t2");
      chk("t2_prg_dout", 32'(prg_dout), 32'h11);

      // PRG read refused by the mapper: open bus, no request.
      quiet(); prg_read = 1; prg_allow = 0;
      tick("t3");
      chk("t3_req", 32'(mem_bus.mem_req), 0);
      chk("t3_prg_dout", 32'(prg_dout), 32'h0FF);

      // PRG write that is never acknowledged.
      quiet(); prg_write = 1; prg_aout = 22'h3C0010; prg_din = 8'h3C;
      tick("t4");
      chk("t4_wdata", 32'(mem_bus.mem_wdata), 32'h3C);
      hi = mem_bus.mem_req ? 1 : 0;
      for (int i = 0; i < 40 && mem_bus.mem_req; i++) begin
         quiet(); tick("t4");
         if (mem_bus.mem_req) hi++;
      end
      chk("t4_req_cycles", 32'(hi), 32'(TO));
      chk("t4_err", 32'(err_flags), 32'b10);

      // Repeated CHR read while in flight.
      quiet(); reset = 1; tick("t5");
      quiet(); chr_read = 1; chr_aout = 22'h000100;
      tick("t5");
      rises = mem_bus.mem_req ? 1 : 0;
      prev = mem_bus.mem_req;
      quiet(); chr_read = 1; chr_aout = 22'h000200;
      tick("t5");
      for (int i = 0; i < 6; i++) begin
         quiet();
         if (i == 1) begin mem_bus.mem_ack = 1; mem_bus.mem_rdata = 8'h9C; end
         tick("t5");
         if (mem_bus.mem_req && !prev) rises++;
         prev = mem_bus.mem_req;
      end
      chk("t5_ovr", 32'(err_flags[0]), 1);
      chk("t5_one_req", 32'(rises), 1);
      chk("t5_chr_dout", 32'(chr_dout), 32'h9C);

      // Reset during BUSY followed by a stale ack.
      quiet(); chr_read = 1; chr_aout = 22'h0ABCDE;
      tick("t6");
      quiet(); reset = 1; tick("t6");
      quiet(); mem_bus.mem_ack = 1; mem_bus.mem_rdata = 8'h77;
      tick("t6");
      chk("t6_req", 32'(mem_bus.mem_req), 0);
      chk("t6_chr_dout", 32'(chr_dout), 32'h0FF);
      quiet(); chr_read = 1; chr_aout = 22'h000555;
      tick("t6");
      chk("t6_idle_issue", 32'(mem_bus.mem_req), 1);
      quiet(); mem_bus.mem_ack = 1; mem_bus.mem_rdata = 8'h66;
      tick("t6");

      // Randomized traffic.
      for (int c = 0; c < 3000; c++) begin
         logic [1:0] k;
         quiet();
         reset = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 3) == 0) begin
            k = 2'($urandom_range(1, 3));
            prg_read = k[0]; prg_write = k[1];
            prg_allow = ($urandom_range(0, 4) != 0);
            prg_aout = AW'($urandom); prg_din = 8'($urandom);
         end
         if ($urandom_range(0, 2) == 0) begin
            k = 2'($urandom_range(1, 3));
            chr_read = k[0]; chr_write = k[1];
            chr_allow = ($urandom_range(0, 4) != 0);
            chr_aout = AW'($urandom); chr_din = 8'($urandom);
         end
         mem_bus.mem_ack = m_busy ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 19) == 0);
         mem_bus.mem_rdata = 8'($urandom);
         tick("rnd");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
